reg_scoreboard: RTL
===================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port issue_valid, input, 1 bit: an instruction leaves EX this cycle.
REQ-004 The block SHALL have port RegWriteE, input, 1 bit: the issuing instruction writes the register file.
REQ-005 The block SHALL have port WriteRegE, input, 5 bits: destination register of the issuing instruction (RtE/RdE as selected by RegDstE).
REQ-006 The block SHALL have port wb_valid, input, 1 bit: a register-file write retires this cycle.
REQ-007 The block SHALL have port WriteRegW, input, 5 bits: destination of the retiring write.
REQ-008 The block SHALL have ports RsD and RtD, inputs, 5 bits each: source registers of the instruction in decode.
REQ-009 The block SHALL have port flush_all, input, 1 bit: debugger restart; discard all tracking.
REQ-010 The block SHALL have port drain_req, input, 1 bit, level: debugger halt request.
REQ-011 The block SHALL have port StallD, output, 1 bit: hold decode, because a source register is pending.
REQ-012 The block SHALL have port issue_block, output, 1 bit: blocks new issue while draining.
REQ-013 The block SHALL have port drained, output, 1 bit: no writes in flight, halt may proceed.
REQ-014 The block SHALL have port pending_count, output, 6 bits: number of registers with a nonzero counter.
REQ-015 The block SHALL have port sb_error, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-016 The block SHALL hold one 2-bit in-flight counter cnt[r] for each r in 1..31; register 0 SHALL never be tracked, and cnt[0] reads as 0.
REQ-017 The inc condition for register r SHALL be issue_valid & RegWriteE & WriteRegE==r, with r!=0.
REQ-018 The dec condition for register r SHALL be wb_valid & WriteRegW==r, with r!=0.
REQ-019 Counter update per register:
- inc only: +1.
- dec only: -1.
- inc and dec in the same cycle: unchanged.
REQ-020 Overflow: inc only with cnt==3 SHALL leave the counter at 3 and set sb_error.
REQ-021 Underflow: dec only with cnt==0 SHALL leave the counter at 0 and set sb_error.
REQ-022 sb_error SHALL stay set until reset or flush_all.
REQ-023 StallD SHALL be combinational from the registered counters: (RsD!=0 & cnt[RsD]!=0) | (RtD!=0 & cnt[RtD]!=0).
REQ-024 A same-cycle writeback SHALL NOT clear StallD in that cycle; StallD falls the cycle after the counter reaches 0.
REQ-025 pending_count SHALL be registered and equal the number of nonzero counters after the current edge's update, in the range 0..31.
REQ-026 flush_all SHALL synchronously zero all counters, sb_error and pending_count, and force the FSM to IDLE.
REQ-027 flush_all SHALL take priority over issue, writeback and drain in the same cycle.
REQ-028 The drain FSM SHALL have three states: IDLE, DRAINING and DRAINED.
REQ-029 IDLE SHALL go to DRAINING when drain_req=1.
REQ-030 DRAINING SHALL go to DRAINED when all counters are 0 after the current update, and to IDLE if drain_req falls first.
REQ-031 DRAINED SHALL go to IDLE when drain_req=0.
REQ-032 DRAINED SHALL go back to DRAINING if a counter becomes nonzero, for example from an issue that was already in flight.
REQ-033 Outputs per state:
- issue_block=1 in DRAINING and DRAINED.
- drained=1 only in DRAINED.
- Both outputs are registered state decodes.
REQ-034 With drain_req=1 and all counters already 0 in IDLE, the FSM SHALL pass through DRAINING for one cycle, so drained asserts 2 cycles after drain_req.
REQ-035 Issue and writeback SHALL continue to update the counters in every FSM state; issue_block is advisory to the hazard logic.

Reset
REQ-036 On reset assertion, asynchronously and independent of clk:
- all cnt = 0.
- sb_error = 0.
- pending_count = 0.
- FSM = IDLE.
- issue_block = 0.
- drained = 0.
- StallD = 0 for any RsD/RtD.
REQ-037 On reset deassertion, the first clk edge SHALL process inputs normally.
REQ-038 Reset asserted during DRAINING SHALL abandon the drain.

Verification
REQ-039 Issue r5 (RegWriteE=1), then RsD=5 -> StallD=1 from the next cycle; wb r5 3 cycles later -> StallD=0 the cycle after the wb edge; pending_count 1 -> 0.
REQ-040 Issue r0 with RegWriteE=1, RsD=0 -> no counter change, StallD=0, pending_count=0.
REQ-041 Two issues to r7, then one wb r7 -> cnt[7]=1 and StallD still 1; same-cycle issue r7 + wb r7 -> cnt unchanged.
REQ-042 Four issues to r9 with no wb -> cnt=3 and sb_error=1; wb to r12 with cnt 0 -> sb_error=1 sticky; flush_all -> all zero, sb_error=0.
REQ-043 drain_req=1 with r3 pending -> DRAINING, issue_block=1, drained=0; wb r3 -> drained=1 on the following cycle; drain_req=0 -> IDLE, issue_block=0.
REQ-044 Async reset pulse mid-DRAINING with 4 pending registers -> outputs zero immediately, without waiting for clk.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register-file write scoreboard: per-register in-flight counters drive the decode stall,
// plus a debugger drain FSM that reports when no register writes remain outstanding.
module reg_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic       RegWriteE,
  input  logic [4:0] WriteRegE,
  input  logic       wb_valid,
  input  logic [4:0] WriteRegW,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       flush_all,
  input  logic       drain_req,
  output logic       StallD,
  output logic       issue_block,
  output logic       drained,
  output logic [5:0] pending_count,
  output logic       sb_error
);

  typedef enum logic [1:0] {IDLE, DRAINING, DRAINED} state_t;

  state_t      state_q;
  logic        issue_block_q;
  logic        drained_q;
  logic [1:0]  cnt_q [32];
  logic [1:0]  cnt_d [32];
  logic        err_q, err_d;
  logic [5:0]  pend_q, pend_d;
  logic [31:0] inc_v, dec_v;
  logic        all_zero_d;

  // One-hot increment/decrement requests; bit 0 is never set so r0 stays untracked.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 1; r < 32; r++) begin
      inc_v[r] = issue_valid & RegWriteE & (WriteRegE == r[4:0]);
      dec_v[r] = wb_valid & (WriteRegW == r[4:0]);
    end
  end

  always_comb begin
    err_d    = err_q;
    pend_d   = '0;
    cnt_d[0] = 2'd0;
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_v[r] && !dec_v[r]) begin
        if (cnt_q[r] == 2'd3) err_d = 1'b1;
        else                  cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (dec_v[r] && !inc_v[r]) begin
        if (cnt_q[r] == 2'd0) err_d = 1'b1;
        else                  cnt_d[r] = cnt_q[r] - 2'd1;
      end
      if (cnt_d[r] != 2'd0) pend_d = pend_d + 6'd1;
    end
    if (flush_all) begin
      for (int r = 0; r < 32; r++) cnt_d[r] = 2'd0;
      err_d  = 1'b0;
      pend_d = '0;
    end
  end

  assign all_zero_d = (pend_d == 6'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= 2'd0;
      err_q  <= 1'b0;
      pend_q <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      err_q  <= err_d;
      pend_q <= pend_d;
    end
  end

  // Drain FSM judges emptiness on the post-update counters, so a retiring write counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      issue_block_q <= 1'b0;
      drained_q     <= 1'b0;
    end else if (flush_all) begin
      state_q       <= IDLE;
      issue_block_q <= 1'b0;
      drained_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (drain_req) begin
            state_q       <= DRAINING;
            issue_block_q <= 1'b1;
            drained_q     <= 1'b0;
          end
        end
        DRAINING: begin
          if (!drain_req) begin
            state_q       <= IDLE;
            issue_block_q <= 1'b0;
            drained_q     <= 1'b0;
          end else if (all_zero_d) begin
            state_q       <= DRAINED;
            issue_block_q <= 1'b1;
            drained_q     <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            state_q       <= IDLE;
            issue_block_q <= 1'b0;
            drained_q     <= 1'b0;
          end else if (!all_zero_d) begin
            state_q       <= DRAINING;
            issue_block_q <= 1'b1;
            drained_q     <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          issue_block_q <= 1'b0;
          drained_q     <= 1'b0;
        end
      endcase
    end
  end

  assign StallD        = ((RsD != 5'd0) && (cnt_q[RsD] != 2'd0)) ||
                         ((RtD != 5'd0) && (cnt_q[RtD] != 2'd0));
  assign issue_block   = issue_block_q;
  assign drained       = drained_q;
  assign pending_count = pend_q;
  assign sb_error      = err_q;

endmodule
